// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix multiplier.
// Optional build macro MM_SAT_EN (saturating stores) is handled in mac_unit.
package matrix_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int acc_width(input int dim, input int dw);
        return 2 * dw + $clog2(dim);
    endfunction

    function automatic int elem_lsb(input int r, input int c,
                                    input int dim, input int dw);
        return (r * dim + c) * dw;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_mac_unit.sv
// Time-shared multiply-accumulate with DW-wide element output.
// Build macro MM_SAT_EN: overflowing elements saturate instead of wrapping.
module mac_unit
    import matrix_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 34
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          last,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] elem,
    output logic          elem_ovf
);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [2*DW-1:0]   prod;
    logic [ACC_W-1:0]  sum;

    // Product, running sum and the element value that would be stored now
    always_comb begin
        prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        sum      = acc_q + {{(ACC_W - 2 * DW){1'b0}}, prod};
        elem_ovf = |sum[ACC_W-1:DW];
`ifdef MM_SAT_EN
        elem     = elem_ovf ? {DW{1'b1}} : sum[DW-1:0];
`else
        elem     = sum[DW-1:0];
`endif
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = last ? '0 : sum;
        end
    end

    // Accumulator register; restarts at zero after each finished element
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mult_seq.sv
// Sequential R = A x B (or A x B^T) using one shared MAC, DIM^3 cycles.
// Build macro MM_SAT_EN selects saturating instead of wrapping stores.
module matrix_mult_seq
    import matrix_pkg::*;
#(
    parameter int DIM = 4,
    parameter int DW  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  transpose_b,
    input  logic [DIM*DIM*DW-1:0] m1,
    input  logic [DIM*DIM*DW-1:0] m2,
    output logic [DIM*DIM*DW-1:0] m_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int ACC_W = acc_width(DIM, DW);
    localparam int KW    = $clog2(DIM);
    localparam int MW    = DIM * DIM * DW;
    localparam int IW    = $clog2(MW);
    localparam logic [KW-1:0] LAST = KW'(DIM - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   i_q, i_d;
    logic [KW-1:0]   j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [MW-1:0]   a_q, a_d;
    logic [MW-1:0]   b_q, b_d;
    logic            tb_q, tb_d;
    logic [MW-1:0]   m_out_q, m_out_d;
    logic            ovf_q, ovf_d;

    logic [IW-1:0]   a_idx;
    logic [IW-1:0]   b_idx;
    logic [IW-1:0]   w_idx;
    logic [DW-1:0]   a_el;
    logic [DW-1:0]   b_el;
    logic            k_last;
    logic            mac_clr;
    logic            mac_en;
    logic [DW-1:0]   elem;
    logic            elem_ovf;

    // Operand element selection for the current i/j/k position
    always_comb begin
        k_last = (k_q == LAST);
        a_idx  = IW'(elem_lsb(int'(i_q), int'(k_q), DIM, DW));
        w_idx  = IW'(elem_lsb(int'(i_q), int'(j_q), DIM, DW));
        if (tb_q) begin
            b_idx = IW'(elem_lsb(int'(j_q), int'(k_q), DIM, DW));
        end else begin
            b_idx = IW'(elem_lsb(int'(k_q), int'(j_q), DIM, DW));
        end
        a_el = a_q[a_idx +: DW];
        b_el = b_q[b_idx +: DW];
    end

    mac_unit #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr      (mac_clr),
        .en       (mac_en),
        .last     (k_last),
        .a        (a_el),
        .b        (b_el),
        .elem     (elem),
        .elem_ovf (elem_ovf)
    );

    // FSM next state, k-innermost loop counters and result writeback
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        tb_d    = tb_q;
        m_out_d = m_out_q;
        ovf_d   = ovf_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = m1;
                    b_d     = m2;
                    tb_d    = transpose_b;
                    ovf_d   = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (!k_last) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    m_out_d[w_idx +: DW] = elem;
                    ovf_d = ovf_q | elem_ovf;
                    if (j_q != LAST) begin
                        j_d = j_q + 1'b1;
                    end else begin
                        j_d = '0;
                        if (i_q != LAST) begin
                            i_d = i_q + 1'b1;
                        end else begin
                            i_d     = '0;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, operand and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tb_q    <= 1'b0;
            m_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tb_q    <= tb_d;
            m_out_q <= m_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m_out = m_out_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Bench for matrix_mult_seq: 4x4x16 and 2x2x8 instances against a model.
// Expected stored values follow MM_SAT_EN when the bench is built with it.
module tb_matrix_mult_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         tb0 = 1'b0;
    logic [255:0] m1 = '0;
    logic [255:0] m2 = '0;
    logic [255:0] m_out;
    logic         busy, done, ovf;

    logic         start2 = 1'b0;
    logic         tb2 = 1'b0;
    logic [31:0]  m1b = '0;
    logic [31:0]  m2b = '0;
    logic [31:0]  m_out2;
    logic         busy2, done2, ovf2;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    matrix_mult_seq #(.DIM(4), .DW(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .transpose_b(tb0),
        .m1(m1), .m2(m2), .m_out(m_out),
        .busy(busy), .done(done), .ovf(ovf)
    );

    matrix_mult_seq #(.DIM(2), .DW(8)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .transpose_b(tb2),
        .m1(m1b), .m2(m2b), .m_out(m_out2),
        .busy(busy2), .done(done2), .ovf(ovf2)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint get_el(input logic [255:0] v,
                                      input int idx, input int dw);
        longint e = 0;
        for (int bi = 0; bi < dw; bi++) e[bi] = v[idx * dw + bi];
        return e;
    endfunction

    // Plain matrix product with store rule; returns {ovf, packed result}
    function automatic logic [256:0] mm(input int dim, input int dw,
                                        input logic [255:0] a,
                                        input logic [255:0] b,
                                        input bit tr);
        logic [255:0] res = '0;
        bit of = 0;
        longint s, eb;
        longint lim = longint'(1) << dw;
        for (int r = 0; r < dim; r++) begin
            for (int c = 0; c < dim; c++) begin
                s = 0;
                for (int k = 0; k < dim; k++) begin
                    eb = tr ? get_el(b, c * dim + k, dw)
                            : get_el(b, k * dim + c, dw);
                    s += get_el(a, r * dim + k, dw) * eb;
                end
                if (s >= lim) begin
                    of = 1;
`ifdef MM_SAT_EN
                    s = lim - 1;
`endif
                end
                s = s % lim;
                for (int bi = 0; bi < dw; bi++)
                    res[(r * dim + c) * dw + bi] = s[bi];
            end
        end
        return {of, res};
    endfunction

    int           cnt[2] = '{0, 0};
    logic [255:0] cur[2] = '{256'b0, 256'b0};
    logic [255:0] nxt[2] = '{256'b0, 256'b0};
    bit           cur_ovf[2] = '{0, 0};
    bit           nxt_ovf[2] = '{0, 0};

    // Model: accept in idle, DIM^3 busy MAC cycles, one done cycle
    always @(posedge clk) begin
        logic [256:0] t;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                cnt[d] = 0;
                cur[d] = '0;
                cur_ovf[d] = 0;
            end else if (cnt[d] > 0) begin
                cnt[d]--;
                if (cnt[d] == 1) begin
                    cur[d] = nxt[d];
                    cur_ovf[d] = nxt_ovf[d];
                end
            end else if (d == 0 ? start : start2) begin
                if (d == 0) t = mm(4, 16, m1, m2, tb0);
                else t = mm(2, 8, {224'b0, m1b}, {224'b0, m2b}, tb2);
                nxt[d] = t[255:0];
                nxt_ovf[d] = t[256];
                cnt[d] = (d == 0) ? 4 ** 3 + 1 : 2 ** 3 + 1;
            end
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 256'(busy), 256'(cnt[0] > 0));
            chk("done", 256'(done), 256'(cnt[0] == 1));
            if (cnt[0] <= 1) begin
                chk("m_out", m_out, cur[0]);
                chk("ovf", 256'(ovf), 256'(cur_ovf[0]));
            end
            chk("busy2", 256'(busy2), 256'(cnt[1] > 0));
            chk("done2", 256'(done2), 256'(cnt[1] == 1));
            if (cnt[1] <= 1) begin
                chk("m_out2", 256'(m_out2), 256'(cur[1][31:0]));
                chk("ovf2", 256'(ovf2), 256'(cur_ovf[1]));
            end
        end
    end

    task automatic run(input int d, input logic [255:0] a,
                       input logic [255:0] b, input bit tr,
                       output int lat, output int bn);
        @(negedge clk);
        if (d == 0) begin
            m1 = a; m2 = b; tb0 = tr; start = 1'b1;
        end else begin
            m1b = a[31:0]; m2b = b[31:0]; tb2 = tr; start2 = 1'b1;
        end
        @(posedge clk);
        lat = 0;
        bn = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            start2 = 1'b0;
            if (d == 0 ? busy : busy2) bn++;
            if (d == 0 ? done : done2) break;
            if (lat >= 200) break;
            @(posedge clk);
            lat++;
        end
    endtask

    logic [255:0] ident, bseq, ones1, onesf;
    int lat, bn, np;

    initial begin
        ident = '0;
        bseq = '0;
        ones1 = '0;
        onesf = '1;
        for (int r = 0; r < 4; r++) ident[(r * 5) * 16 +: 16] = 16'd1;
        for (int e = 0; e < 16; e++) begin
            bseq[e * 16 +: 16] = 16'(e);
            ones1[e * 16 +: 16] = 16'd1;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1;
        chk("rst_m_out", m_out, 256'h0);
        chk("rst_busy", 256'(busy), 256'h0);
        chk("rst_done", 256'(done), 256'h0);
        chk("rst_ovf", 256'(ovf), 256'h0);
        reset = 1'b1;

        run(0, ident, bseq, 1'b0, lat, bn);
        chk("ident_lat", 256'(lat), 256'd64);
        chk("ident_busy_cycles", 256'(bn), 256'd65);
        chk("ident_res", m_out, bseq);
        chk("ident_el23", 256'(m_out[(2 * 4 + 3) * 16 +: 16]), 256'd11);
        chk("ident_ovf", 256'(ovf), 256'd0);

        run(0, ident, bseq, 1'b1, lat, bn);
        chk("tr_lat", 256'(lat), 256'd64);
        chk("tr_el01", 256'(m_out[1 * 16 +: 16]), 256'd4);
        chk("tr_el10", 256'(m_out[4 * 16 +: 16]), 256'd1);

        run(0, onesf, onesf, 1'b0, lat, bn);
`ifdef MM_SAT_EN
        chk("ffff_el33", 256'(m_out[15 * 16 +: 16]), 256'hFFFF);
`else
        chk("ffff_el33", 256'(m_out[15 * 16 +: 16]), 256'h0004);
`endif
        chk("ffff_ovf", 256'(ovf), 256'd1);

        @(negedge clk);
        m1 = ones1; m2 = ones1; tb0 = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        np = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) np++;
        end
        chk("busy_start_pulses", 256'(np), 256'd1);
        chk("ones_el00", 256'(m_out[15:0]), 256'd4);
        chk("ones_ovf", 256'(ovf), 256'd0);

        @(negedge clk);
        m1 = bseq; m2 = ones1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_m_out", m_out, 256'h0);
        chk("abort_busy", 256'(busy), 256'd0);
        np = 0;
        repeat (100) begin
            @(negedge clk);
            if (done) np++;
        end
        chk("abort_no_done", 256'(np), 256'd0);

        run(0, ident, bseq, 1'b0, lat, bn);
        chk("after_abort_res", m_out, bseq);

        run(1, 256'h04030201, 256'h08070605, 1'b0, lat, bn);
        chk("d2_lat", 256'(lat), 256'd8);
        chk("d2_busy_cycles", 256'(bn), 256'd9);
        chk("d2_res", 256'(m_out2), 256'h322B1613);
        chk("d2_ovf", 256'(ovf2), 256'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
Parametrised, multi-cycle successor to the single-shot matrix multiplier. It computes R = A x B, or R = A x B^T, for DIM x DIM unsigned matrices with a single time-shared MAC, which keeps area low. A start/busy/done handshake sits on the instruction-decode side. Result and status are held stable until the next accepted start.

Parameters:
- DIM, 4, matrix dimension (rows = cols); legal 2..8.
- DW, 16, element width in bits (unsigned).
- ACC_W, 2*DW+$clog2(DIM), accumulator width; derived, not overridable.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- start  in  1  request; accepted only in IDLE.
- transpose_b  in  1  0: R=A*B; 1: R=A*B^T; sampled on accept edge.
- m1  in  DIM*DIM*DW  matrix A; element [r][c] at bits (r*DIM+c)*DW +: DW.
- m2  in  DIM*DIM*DW  matrix B; same packing.
- m_out  out  DIM*DIM*DW  result matrix; same packing.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: result valid.
- ovf  out  1  sticky per operation: any element exceeded DW bits.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, m_out=0, busy=0, done=0, ovf=0, counters=0. Reset has priority over everything. Reset mid-operation aborts; no done pulse is produced.
- States: IDLE -> MAC -> DONE -> IDLE.
- IDLE: on an edge with start=1, register m1, m2, transpose_b into internal operand regs; clear acc, ovf, i/j/k; go to MAC. m_out keeps its old value until overwritten element by element.
- MAC: k is innermost, then j (col), then i (row).
  - Each cycle: acc += A[i][k] * Bsel, where Bsel = B[k][j] (transpose_b=0) or B[j][k] (transpose_b=1).
  - When k==DIM-1: write element [i][j] of m_out from acc+product; flag overflow if that value >= 2^DW; clear acc; advance j, then i.
  - After writing element [DIM-1][DIM-1], go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE (and in MAC).
- Latency: DIM^3 clocks from accept edge to the done rising edge. DIM=4 -> 64 cycles; next start can be accepted at the earliest DIM^3+2 edges after the previous accept.
- Width: products DW x DW -> 2*DW; sums in ACC_W, so there is no internal wrap. Default store truncates to the DW LSBs (modulo 2^DW). ovf still reports truncation.
- Input stability: m1/m2 may change after the accept edge without effect.
- start held high through DONE: not re-accepted until the IDLE cycle, so back-to-back operations are one idle cycle apart.

Optional Feature:
- MM_SAT_EN defined: any element whose sum >= 2^DW is stored as 2^DW-1 (all ones), and ovf is set.
- Not defined: the element is stored as sum mod 2^DW, and ovf is still set. Port list is identical in both builds.

Decomposition:
- Package matrix_pkg holds:
  - state encoding (IDLE, MAC, DONE);
  - acc-width function;
  - element index helper elem_lsb(r,c,DIM,DW).
- Sub-module mac_unit: registered acc with clear, multiply-add, and saturate/truncate-to-DW output with an overflow flag (MM_SAT_EN handled inside).
- Top holds the FSM, i/j/k counters and operand/result regs.

Test Plan:
- DIM=4, A=identity, B=elements 0..15, transpose_b=0 -> m_out==B; done exactly 64 clocks after accept edge; busy high 65 cycles; ovf=0.
- Same A, B as above, transpose_b=1 -> m_out==B^T (element [0][1]=4, [1][0]=1).
- A=B=all 0xFFFF -> default build: every element 0x0004, ovf=1. MM_SAT_EN build: every element 0xFFFF, ovf=1.
- A=B=all 1 -> all elements 4; pulse start again at cycle 10 (while busy) -> ignored, single done pulse, no restart.
- Drive reset=0 for one edge at cycle 30 of an operation -> m_out=0, busy=0, no done. New start afterwards -> correct result.
- Parameter sweep DIM=2, DW=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> [[19,22],[43,50]], latency 8.
